// File: rtl/etapa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : etapa_pkg
// Description : Shared types and constants for the ID (decode) stage:
//               opclass enum, RV32I opcodes, decoded beat payload and NOP.
// Revision    : 1.0 - initial release
// ============================================================================
package etapa_pkg;

  typedef enum logic [3:0] {
    OC_LUI     = 4'd0,
    OC_AUIPC   = 4'd1,
    OC_JAL     = 4'd2,
    OC_JALR    = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LOAD    = 4'd5,
    OC_STORE   = 4'd6,
    OC_OPIMM   = 4'd7,
    OC_OP      = 4'd8,
    OC_FENCE   = 4'd9,
    OC_SYSTEM  = 4'd10,
    OC_ILLEGAL = 4'd11
  } opclass_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Payload held in both buffer entries; RV32I so pc/imm are 32 bits.
  typedef struct packed {
    logic [31:0] pc;
    opclass_t    opclass;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        reg_we;
    logic        illegal;
  } decoded_t;

  // Decode of ADDI x0,x0,0 at pc 0.
  localparam decoded_t NOP_DECODED = '{
    pc:       32'd0,
    opclass:  OC_OPIMM,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    funct3:   3'd0,
    funct7b5: 1'b0,
    imm:      32'd0,
    reg_we:   1'b0,
    illegal:  1'b0
  };

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch->decode and decode->execute handshakes plus the
//               flush / load-hazard sideband seen by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
  parameter int XLEN = 32
) ();
  import etapa_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            flush;
  logic            ex_load_valid;
  logic [4:0]      ex_load_rd;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  opclass_t        id_opclass;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic [XLEN-1:0] id_imm;
  logic            id_reg_we;
  logic            id_illegal;

  // Decode stage side.
  modport slave (
    input  if_valid, if_pc, if_instr, flush, ex_load_valid, ex_load_rd, id_ready,
    output if_ready, id_valid, id_pc, id_opclass, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7b5, id_imm, id_reg_we, id_illegal
  );

  // Surrounding pipeline side (fetch, execute).
  modport master (
    output if_valid, if_pc, if_instr, flush, ex_load_valid, ex_load_rd, id_ready,
    input  if_ready, id_valid, id_pc, id_opclass, id_rs1, id_rs2, id_rd,
           id_funct3, id_funct7b5, id_imm, id_reg_we, id_illegal
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decoder
// Description : Purely combinational RV32I field decoder. The pc field of the
//               result is left zero; the stage fills it in.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decoder
  import etapa_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  opclass_t oc;

  // Classify the opcode, then pick register fields and immediate per class.
  always_comb begin
    dec          = '0;
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];

    oc = OC_ILLEGAL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_LUI:    oc = OC_LUI;
        OPC_AUIPC:  oc = OC_AUIPC;
        OPC_JAL:    oc = OC_JAL;
        OPC_JALR:   oc = OC_JALR;
        OPC_BRANCH: oc = OC_BRANCH;
        OPC_LOAD:   oc = OC_LOAD;
        OPC_STORE:  oc = OC_STORE;
        OPC_OPIMM:  oc = OC_OPIMM;
        OPC_OP:     oc = OC_OP;
        OPC_FENCE:  oc = OC_FENCE;
        OPC_SYSTEM: oc = OC_SYSTEM;
        default:    oc = OC_ILLEGAL;
      endcase
    end
    dec.opclass = oc;
    dec.illegal = (oc == OC_ILLEGAL);

    case (oc)
      OC_LUI, OC_AUIPC: begin
        dec.rd  = instr[11:7];
        dec.imm = {instr[31:12], 12'd0};
      end
      OC_JAL: begin
        dec.rd  = instr[11:7];
        dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OC_JALR, OC_LOAD, OC_OPIMM, OC_FENCE, OC_SYSTEM: begin
        dec.rs1 = instr[19:15];
        dec.rd  = instr[11:7];
        dec.imm = {{20{instr[31]}}, instr[31:20]};
      end
      OC_BRANCH: begin
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OC_STORE: begin
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OC_OP: begin
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
      end
      default: ;
    endcase

    // FENCE and branch/store never write; ILLEGAL has rd forced to zero above.
    dec.reg_we = (dec.rd != 5'd0) && (oc != OC_FENCE) && (oc != OC_ILLEGAL);
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : ID pipeline stage. Decodes fetch beats at the input and
//               buffers decoded payloads in a 2-entry skid buffer (main +
//               skid), with load-use interlock and branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import etapa_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit RESET_NOP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam decoded_t RST_VAL = RESET_NOP ? NOP_DECODED : decoded_t'('0);

  decoded_t        w_dec;
  decoded_t        w_in;
  logic [XLEN-1:0] w_pc;
  decoded_t        r_main;
  decoded_t        r_skid;
  logic            r_main_valid;
  logic            r_skid_valid;
  logic            w_haz;
  logic            w_cons;
  logic            w_accept;
  logic            w_main_free;

  rv32i_decoder u_dec (
    .instr (bus.if_instr),
    .dec   (w_dec)
  );

  assign w_pc = bus.if_pc;

  // Attach the fetch pc to the freshly decoded fields.
  always_comb begin
    w_in    = w_dec;
    w_in.pc = w_pc;
  end

  // Load-use interlock: unused source registers decode as x0, so they never match.
  assign w_haz = r_main_valid && bus.ex_load_valid && (bus.ex_load_rd != 5'd0) &&
                 ((bus.ex_load_rd == r_main.rs1) || (bus.ex_load_rd == r_main.rs2));

  assign bus.id_valid = r_main_valid && !w_haz;
  assign w_cons       = bus.id_valid && bus.id_ready;
  assign bus.if_ready = !r_skid_valid;
  assign w_accept     = bus.if_valid && bus.if_ready;
  assign w_main_free  = !r_main_valid || w_cons;

  // Buffer update: flush kills everything, otherwise skid drains into main first
  // so beats leave in arrival order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= RST_VAL;
      r_skid       <= RST_VAL;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= w_accept;
        if (w_accept) r_skid <= w_in;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main <= w_in;
      end
    end else if (w_accept) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.id_pc       = r_main.pc;
  assign bus.id_opclass  = r_main.opclass;
  assign bus.id_rs1      = r_main.rs1;
  assign bus.id_rs2      = r_main.rs2;
  assign bus.id_rd       = r_main.rd;
  assign bus.id_funct3   = r_main.funct3;
  assign bus.id_funct7b5 = r_main.funct7b5;
  assign bus.id_imm      = r_main.imm;
  assign bus.id_reg_we   = r_main.reg_we;
  assign bus.id_illegal  = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage: vector table with
//               hand-decoded expectations feeding an in-order scoreboard,
//               plus directed backpressure, hazard, flush and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32), .RESET_NOP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  oc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];
  vec_t sb [$];
  vec_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare consumed beats against the oldest accepted one, then
  // record any beat accepted on the coming edge.
  always @(negedge clk) begin
    if (reset || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.id_valid && bus.id_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got pc 0x%08h expected no beat", bus.id_pc);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("sb_pc",     bus.id_pc, e.pc);
          chk("sb_opcls",  32'(bus.id_opclass), 32'(e.oc));
          chk("sb_rs1",    32'(bus.id_rs1), 32'(e.rs1));
          chk("sb_rs2",    32'(bus.id_rs2), 32'(e.rs2));
          chk("sb_rd",     32'(bus.id_rd), 32'(e.rd));
          chk("sb_funct3", 32'(bus.id_funct3), 32'(e.f3));
          chk("sb_f7b5",   32'(bus.id_funct7b5), 32'(e.f7));
          chk("sb_imm",    bus.id_imm, e.imm);
          chk("sb_reg_we", 32'(bus.id_reg_we), 32'(e.we));
          chk("sb_illegal",32'(bus.id_illegal), 32'(e.ill));
        end
      end
      if (bus.if_valid && bus.if_ready) sb.push_back(cur);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    cur          = tbl[idx];
    bus.if_valid = 1'b1;
    bus.if_pc    = tbl[idx].pc;
    bus.if_instr = tbl[idx].instr;
  endtask

  // Present a beat and hold it until an edge with if_ready high takes it.
  task automatic send(input int idx);
    logic acc;
    acc = 1'b0;
    drive(idx);
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = bus.if_ready;
      step();
    end
    bus.if_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept of pc 0x%08h", tbl[idx].pc);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_nop_payload(input string tag);
    chk({tag, "_opcls"},  32'(bus.id_opclass), 32'd7);
    chk({tag, "_pc"},     bus.id_pc, 32'd0);
    chk({tag, "_rd"},     32'(bus.id_rd), 32'd0);
    chk({tag, "_imm"},    bus.id_imm, 32'd0);
    chk({tag, "_reg_we"}, 32'(bus.id_reg_we), 32'd0);
    chk({tag, "_illegal"},32'(bus.id_illegal), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              pc      instr         oc rs1 rs2 rd f3 f7 imm           we ill
    tbl[0]  = '{32'h000, 32'h00500093,  7, 0, 0, 1,  0, 0, 32'h00000005, 1, 0}; // ADDI x1,x0,5
    tbl[1]  = '{32'h004, 32'hFE20AE23,  6, 1, 2, 0,  2, 1, 32'hFFFFFFFC, 0, 0}; // SW x2,-4(x1)
    tbl[2]  = '{32'h008, 32'h002081B3,  8, 1, 2, 3,  0, 0, 32'h00000000, 1, 0}; // ADD x3,x1,x2
    tbl[3]  = '{32'h00C, 32'hFFFFFFFF, 11, 0, 0, 0,  7, 1, 32'h00000000, 0, 1}; // unknown opcode
    tbl[4]  = '{32'h010, 32'h123452B7,  0, 0, 0, 5,  5, 0, 32'h12345000, 1, 0}; // LUI x5
    tbl[5]  = '{32'h014, 32'h00208463,  4, 1, 2, 0,  0, 0, 32'h00000008, 0, 0}; // BEQ x1,x2,+8
    tbl[6]  = '{32'h018, 32'h0081A203,  5, 3, 0, 4,  2, 0, 32'h00000008, 1, 0}; // LW x4,8(x3)
    tbl[7]  = '{32'h01C, 32'h010000EF,  2, 0, 0, 1,  0, 0, 32'h00000010, 1, 0}; // JAL x1,+16
    tbl[8]  = '{32'h020, 32'h00008067,  3, 1, 0, 0,  0, 0, 32'h00000000, 0, 0}; // JALR x0,0(x1)
    tbl[9]  = '{32'h024, 32'h00500090, 11, 0, 0, 0,  0, 0, 32'h00000000, 0, 1}; // low bits 00
    tbl[10] = '{32'h028, 32'h00001517,  1, 0, 0, 10, 1, 0, 32'h00001000, 1, 0}; // AUIPC x10,1

    reset             = 1'b1;
    bus.if_valid      = 1'b0;
    bus.if_pc         = '0;
    bus.if_instr      = '0;
    bus.flush         = 1'b0;
    bus.ex_load_valid = 1'b0;
    bus.ex_load_rd    = '0;
    bus.id_ready      = 1'b0;
    cur               = tbl[0];

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_if_ready", 32'(bus.if_ready), 32'd1);
    chk_nop_payload("rst");
    step();
    reset = 1'b0;

    // Table: every vector, one-cycle latency, scoreboard checks payload
    bus.id_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(i);
      @(negedge clk);
      chk("latency_valid", 32'(bus.id_valid), 32'd1);
      step();
    end
    drain();

    // Backpressure: A in main, B in skid, C held by fetch, then release
    bus.id_ready = 1'b0;
    send(4);
    send(6);
    drive(7);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_if_ready", 32'(bus.if_ready), 32'd0);
      chk("bp_id_valid", 32'(bus.id_valid), 32'd1);
      chk("bp_id_pc",    bus.id_pc, tbl[4].pc);
      step();
    end
    bus.id_ready = 1'b1;
    send(7);
    drain();

    // Load-use hazard on rs1 for two cycles
    bus.id_ready = 1'b0;
    send(2);
    bus.ex_load_valid = 1'b1;
    bus.ex_load_rd    = 5'd1;
    bus.id_ready      = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("haz_rs1_stall", 32'(bus.id_valid), 32'd0);
      step();
    end
    bus.ex_load_valid = 1'b0;
    @(negedge clk);
    chk("haz_release", 32'(bus.id_valid), 32'd1);
    step();
    drain();

    // Hazard on rs2, then a load to the ADD's own rd does not stall
    bus.id_ready = 1'b0;
    send(2);
    bus.ex_load_valid = 1'b1;
    bus.ex_load_rd    = 5'd2;
    bus.id_ready      = 1'b1;
    @(negedge clk);
    chk("haz_rs2_stall", 32'(bus.id_valid), 32'd0);
    step();
    bus.ex_load_rd = 5'd3;
    @(negedge clk);
    chk("haz_rd_only", 32'(bus.id_valid), 32'd1);
    step();
    bus.ex_load_valid = 1'b0;
    drain();

    // Load to x0 never stalls
    bus.id_ready = 1'b0;
    send(2);
    bus.ex_load_valid = 1'b1;
    bus.ex_load_rd    = 5'd0;
    bus.id_ready      = 1'b1;
    @(negedge clk);
    chk("haz_x0_nostall", 32'(bus.id_valid), 32'd1);
    step();
    bus.ex_load_valid = 1'b0;
    drain();

    // Flush with both entries full and a beat on the input
    bus.id_ready = 1'b0;
    send(0);
    send(1);
    drive(2);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("flush_id_valid", 32'(bus.id_valid), 32'd0);
    chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
    step();
    bus.id_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("flush_no_stale", 32'(bus.id_valid), 32'd0);
      step();
    end

    // Flush while if_ready is high: the incoming beat must also be dropped
    bus.id_ready = 1'b0;
    send(0);
    drive(1);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("flush_in_drop", 32'(bus.id_valid), 32'd0);
      step();
    end

    // Reset mid-operation with both entries full
    bus.id_ready = 1'b0;
    send(0);
    send(1);
    drive(2);
    reset = 1'b1;
    step();
    reset        = 1'b0;
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("mrst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("mrst_if_ready", 32'(bus.if_ready), 32'd1);
    chk_nop_payload("mrst");
    step();
    bus.id_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(bus.id_valid), 32'd0);
      step();
    end
    send(8);
    drain();

    chk("final_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
